ram_blit_engine: RTL

- Block-move/fill engine and access arbiter sitting directly upstream of the single-port byte RAM (spram); drives its address/data/wren and consumes its registered q.
- Idle: CPU bus passes straight through to the RAM.
- Busy: engine owns the RAM and holds the CPU off with halt, as the Williams special chip does during a blit. Engine copies or fills a run of bytes inside the same RAM.

---
 rtl/ram_blit_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_blit_engine.sv
// ram_blit_engine: block copy / fill engine and CPU access arbiter in front of
// a single-port byte RAM with registered read data. While idle the CPU bus is
// passed straight through to the RAM. While an operation runs the engine owns
// the RAM and holds the CPU off with halt.
module ram_blit_engine #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   // CPU side
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_data,
   input  logic                  cpu_wren,
   output logic [DATA_WIDTH-1:0] cpu_q,
   // operation request
   input  logic                  start,
   input  logic                  fill_mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic [DATA_WIDTH-1:0] fill_value,
   // status
   output logic                  busy,
   output logic                  halt,
   output logic                  done,
   // RAM side
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  fill_mode_q, fill_mode_d;
   logic [DATA_WIDTH-1:0] fill_value_q, fill_value_d;

   // Next-state logic: latch the request in IDLE, step pointers after each write.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      cnt_d        = cnt_q;
      fill_mode_d  = fill_mode_q;
      fill_value_d = fill_value_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d        = src_addr;
               dst_d        = dst_addr;
               cnt_d        = length;
               fill_mode_d  = fill_mode;
               fill_value_d = fill_value;
               if (length == ADDR_ZERO) begin
                  state_d = ST_FIN;
               end else if (fill_mode) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            // ram_q carries the source byte in the following WR cycle
            state_d = ST_WR;
         end
         ST_WR: begin
            src_d = src_q + ADDR_ONE;
            dst_d = dst_q + ADDR_ONE;
            cnt_d = cnt_q - ADDR_ONE;
            // a count of one (or a corrupted zero) means this write is the last
            if (cnt_q <= ADDR_ONE) begin
               state_d = ST_FIN;
            end else if (fill_mode_q) begin
               state_d = ST_WR;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and operand registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         src_q        <= ADDR_ZERO;
         dst_q        <= ADDR_ZERO;
         cnt_q        <= ADDR_ZERO;
         fill_mode_q  <= 1'b0;
         fill_value_q <= DATA_ZERO;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cnt_q        <= cnt_d;
         fill_mode_q  <= fill_mode_d;
         fill_value_q <= fill_value_d;
      end
   end

   // RAM port mux and status decode; start never reaches ram_wren combinationally.
   always_comb begin
      ram_address = cpu_address;
      ram_data    = cpu_data;
      ram_wren    = cpu_wren;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_RD: begin
            ram_address = src_q;
            ram_data    = DATA_ZERO;
            ram_wren    = 1'b0;
            busy        = 1'b1;
         end
         ST_WR: begin
            ram_address = dst_q;
            ram_wren    = 1'b1;
            busy        = 1'b1;
            if (fill_mode_q) begin
               ram_data = fill_value_q;
            end else begin
               ram_data = ram_q;
            end
         end
         ST_FIN: begin
            // CPU passthrough is already back in this cycle
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign halt  = busy;
   assign cpu_q = ram_q;

endmodule
